instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage feeding memoryRegister: keeps the program counter, issues word reads to
//  Mem_D32b_A16b, captures the returned 32-bit word plus its 16-bit address, and presents
//  them on a valid/ready handshake. instr_data/instr_addr drive memoryRegister
//  dataInput/dirrOutput path. Supports branch redirect and a fetch enable.
// PARAMETERS
//  ADDR_W    16      address width (word-addressed)
//  DATA_W    32      instruction word width
//  RESET_PC  16'h0   PC value loaded on reset
// PORTS
//  clk          in   1       single clock; all state on posedge
//  reset        in   1       asynchronous, active-high reset
//  fetch_en     in   1       1 = fetching allowed; 0 = stop after current handshake
//  redirect     in   1       1-cycle pulse: load PC from redirect_pc, flush in-flight fetch
//  redirect_pc  in   ADDR_W  new PC on redirect
//  mem_address  out  ADDR_W  read address to memory
//  mem_rd       out  1       read strobe, high in ISSUE only
//  mem_write    out  1       tied 0 (fetch never writes)
//  mem_data_in  in   DATA_W  memory read data, valid the cycle after ISSUE
//  instr_data   out  DATA_W  captured instruction
//  instr_addr   out  ADDR_W  address instr_data came from
//  instr_valid  out  1       instr_data/instr_addr valid
//  instr_ready  in   1       consumer accepts when valid & ready at posedge
//  fetch_count  out  16      instructions delivered (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, mem_address=0, mem_rd=0,
//   instr_data=0, instr_addr=0, instr_valid=0, fetch_count=0. Release mid-operation: restart clean.
//  FSM states IDLE, ISSUE, CAPTURE, HOLD:
//   IDLE:    fetch_en=1 -> ISSUE; else stay.
//   ISSUE:   mem_address=pc, mem_rd=1 -> CAPTURE.
//   CAPTURE: instr_data<=mem_data_in, instr_addr<=pc, instr_valid<=1, pc<=pc+1 -> HOLD.
//   HOLD:    valid held, data/addr stable until handshake. valid&ready -> valid<=0;
//            then fetch_en ? ISSUE : IDLE. No handshake -> stay HOLD.
//  Latency: ISSUE to instr_valid = 2 cycles; max throughput 1 instr per 3 cycles.
//  PC arithmetic: modulo 2^ADDR_W; 16'hFFFF + 1 wraps to 16'h0000, no flag.
//  Redirect (priority over all but reset), any state: pc<=redirect_pc, instr_valid<=0,
//   captured/in-flight word discarded, next state ISSUE if fetch_en else IDLE.
//   Redirect in CAPTURE: returned word dropped, pc not incremented.
//   Redirect with valid&ready in same HOLD cycle: handshake counts as completed
//   (counter increments), then redirect applies.
//  fetch_en dropped in ISSUE/CAPTURE: current fetch finishes and is delivered; stop after.
//  ready high while valid=0: ignored.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: fetch_count increments by 1 on every valid&ready handshake,
//   wraps 16'hFFFF -> 0, cleared only by reset.
//  Not defined: counter logic omitted, fetch_count tied to 16'h0000; port list unchanged.
// TESTING
//  T1 reset, RESET_PC=0, mem[0]=ACEDCAFE, mem[1]=DEADBEEF, ready=1, fetch_en=1 -> instr_data
//     ACEDCAFE/addr 0 then DEADBEEF/addr 1, valid pulses every 3rd cycle.
//  T2 hold ready=0 for 5 cycles in HOLD -> data/addr/valid stable, mem_rd stays 0, pc not advanced.
//  T3 redirect pulse to 16'h0040 during CAPTURE -> in-flight word never shown valid;
//     next delivered instr_addr = 16'h0040.
//  T4 redirect_pc=16'hFFFF, ready=1 -> delivered addrs FFFF then 0000 (wrap).
//  T5 assert reset mid-HOLD -> instr_valid, pc, outputs reset same cycle asynchronously; restart at RESET_PC.
//  T6 with FETCH_PERF_CNT_EN, 10 handshakes -> fetch_count=10; without macro -> 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, one-word reads to memory, valid/ready delivery of {data, addr}; 2-cycle ISSUE->valid, 1 instr per 3 cycles.
// Optional FETCH_PERF_CNT_EN macro enables the delivered-instruction counter on fetch_count.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rd,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                handshake;

  assign handshake = valid_q & instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (fetch_en) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d  = mem_data_in;
        addr_d  = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = fetch_en ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides everything above; a word returning in CAPTURE is dropped unpublished.
    if (redirect) begin
      pc_d    = redirect_pc;
      data_d  = data_q;
      addr_d  = addr_q;
      valid_d = 1'b0;
      state_d = fetch_en ? ISSUE : IDLE;
    end
  end

  assign mem_rd      = (state_q == ISSUE);
  assign mem_address = mem_rd ? pc_q : '0;
  assign mem_write   = 1'b0;
  assign instr_data  = data_q;
  assign instr_addr  = addr_q;
  assign instr_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] count_q, count_d;

  // A handshake coinciding with a redirect still counts as delivered.
  assign count_d = count_q + {15'd0, handshake};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule
